// File: rtl/srv32_bus_pkg.sv
// rtl/srv32_bus_pkg.sv - shared constants and read-slot type for the data-bus router
package srv32_bus_pkg;

  localparam logic [3:0]  CLINT_BASE   = 4'h9;
  localparam logic [3:0]  DMEM_BASE    = 4'h0;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic       err;
  } rd_slot_t;

endpackage

// File: rtl/srv32_addr_decode.sv
// rtl/srv32_addr_decode.sv - upper-address tag decode to one-hot hit, index and miss
module srv32_addr_decode #(
  parameter int NUM_TGT = 2,
  parameter int TAG_W   = 4,
  parameter logic [NUM_TGT*TAG_W-1:0] TAGS = '0
) (
  input  logic [TAG_W-1:0]   tag,
  output logic [NUM_TGT-1:0] hit,
  output logic [2:0]         idx,
  output logic               miss
);

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    idx  = 3'd0;
    miss = 1'b1;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (tag == TAGS[i*TAG_W +: TAG_W]) begin
        idx  = i[2:0];
        miss = 1'b0;
      end
    end
    hit = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      hit[i] = !miss && (idx == i[2:0]);
    end
  end

endmodule

// File: rtl/srv32_dbus_router.sv
// rtl/srv32_dbus_router.sv - core data-bus router to NUM_TGT targets with read pipeline and error capture
module srv32_dbus_router
  import srv32_bus_pkg::*;
#(
  parameter int NUM_TGT = 2,
  parameter int TAG_W   = 4,
  parameter logic [NUM_TGT*TAG_W-1:0] TAGS = {CLINT_BASE, DMEM_BASE},
  parameter int RD_LAT  = 1,
  parameter int ERR_EN  = 0,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   s_wready,
  output logic                   s_wvalid,
  input  logic [31:0]            s_waddr,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_rready,
  output logic                   s_rvalid,
  input  logic [31:0]            s_raddr,
  output logic                   s_rresp,
  output logic [31:0]            s_rdata,
  output logic [NUM_TGT-1:0]     m_wready,
  input  logic [NUM_TGT-1:0]     m_wvalid,
  output logic [NUM_TGT*32-1:0]  m_waddr,
  output logic [NUM_TGT*32-1:0]  m_wdata,
  output logic [NUM_TGT*4-1:0]   m_wstrb,
  output logic [NUM_TGT-1:0]     m_rready,
  input  logic [NUM_TGT-1:0]     m_rvalid,
  output logic [NUM_TGT*32-1:0]  m_raddr,
  input  logic [NUM_TGT-1:0]     m_rresp,
  input  logic [NUM_TGT*32-1:0]  m_rdata,
  input  logic                   err_clr,
  output logic                   err_o,
  output logic [31:0]            err_addr,
  output logic                   err_wr
);

  localparam bit ERR_ON = (ERR_EN != 0);

  logic [NUM_TGT-1:0] rd_hit, wr_hit, rd_sel, wr_sel;
  logic [2:0]         rd_idx, wr_idx;
  logic               rd_miss, wr_miss, rd_err, wr_err, rd_acc;
  rd_slot_t           pipe [RD_LAT];
  rd_slot_t           pipe_out;

  srv32_addr_decode #(.NUM_TGT(NUM_TGT), .TAG_W(TAG_W), .TAGS(TAGS)) u_rd_dec (
    .tag (s_raddr[31 -: TAG_W]),
    .hit (rd_hit),
    .idx (rd_idx),
    .miss(rd_miss)
  );

  srv32_addr_decode #(.NUM_TGT(NUM_TGT), .TAG_W(TAG_W), .TAGS(TAGS)) u_wr_dec (
    .tag (s_waddr[31 -: TAG_W]),
    .hit (wr_hit),
    .idx (wr_idx),
    .miss(wr_miss)
  );

  assign m_waddr = {NUM_TGT{s_waddr}};
  assign m_wdata = {NUM_TGT{s_wdata}};
  assign m_wstrb = {NUM_TGT{s_wstrb}};
  assign m_raddr = {NUM_TGT{s_raddr}};

  assign rd_err = ERR_ON && rd_miss;
  assign wr_err = ERR_ON && wr_miss;

  // Without error responses an unmapped address falls through to target 0.
  always_comb begin
    rd_sel = rd_hit;
    wr_sel = wr_hit;
    if (rd_miss && !ERR_ON) rd_sel[0] = 1'b1;
    if (wr_miss && !ERR_ON) wr_sel[0] = 1'b1;
    m_rready = s_rready ? rd_sel : '0;
    m_wready = s_wready ? wr_sel : '0;
    s_rvalid = rd_err;
    s_wvalid = wr_err;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (rd_sel[i]) s_rvalid = m_rvalid[i];
      if (wr_sel[i]) s_wvalid = m_wvalid[i];
    end
  end

  assign rd_acc = s_rready && s_rvalid;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: rd_acc, idx: rd_idx, err: rd_acc && rd_err};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pipe_out = pipe[RD_LAT-1];

  always_comb begin
    s_rdata = '0;
    s_rresp = 1'b0;
    if (pipe_out.valid) begin
      if (pipe_out.err) begin
        s_rdata = ERR_DATA;
      end else begin
        for (int i = 0; i < NUM_TGT; i++) begin
          if (pipe_out.idx == i[2:0]) begin
            s_rdata = m_rdata[i*32 +: 32];
            s_rresp = m_rresp[i];
          end
        end
      end
    end
  end

  // A fresh error wins over a same-cycle clear; the read side wins a tie.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      err_o    <= 1'b0;
      err_addr <= '0;
      err_wr   <= 1'b0;
    end else if ((s_rready && rd_err) || (s_wready && wr_err)) begin
      if (!err_o || err_clr) begin
        err_o    <= 1'b1;
        err_addr <= (s_rready && rd_err) ? s_raddr : s_waddr;
        err_wr   <= !(s_rready && rd_err);
      end
    end else if (err_clr) begin
      err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_srv32_dbus_router.sv
// tb/tb_srv32_dbus_router.sv - directed self-checking bench for srv32_dbus_router
module tb_srv32_dbus_router;

  logic        clk = 1'b0;
  logic        resetb;
  logic        s_wready, s_rready, err_clr;
  logic [31:0] s_waddr, s_wdata, s_raddr;
  logic [3:0]  s_wstrb;
  logic [1:0]  m_wvalid, m_rvalid, m_rresp;
  logic [63:0] m_rdata;

  logic        a_s_wvalid, a_s_rvalid, a_s_rresp, a_err_o, a_err_wr;
  logic [31:0] a_s_rdata, a_err_addr;
  logic [1:0]  a_m_wready, a_m_rready;
  logic [63:0] a_m_waddr, a_m_wdata, a_m_raddr;
  logic [7:0]  a_m_wstrb;

  logic        b_s_wvalid, b_s_rvalid, b_s_rresp, b_err_o, b_err_wr;
  logic [31:0] b_s_rdata, b_err_addr;
  logic [1:0]  b_m_wready, b_m_rready;
  logic [63:0] b_m_waddr, b_m_wdata, b_m_raddr;
  logic [7:0]  b_m_wstrb;

  logic        c_s_wvalid, c_s_rvalid, c_s_rresp, c_err_o, c_err_wr;
  logic [31:0] c_s_rdata, c_err_addr;
  logic [1:0]  c_m_wready, c_m_rready;
  logic [63:0] c_m_waddr, c_m_wdata, c_m_raddr;
  logic [7:0]  c_m_wstrb;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  srv32_dbus_router u_a (
    .clk(clk), .resetb(resetb),
    .s_wready(s_wready), .s_wvalid(a_s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rready(s_rready), .s_rvalid(a_s_rvalid), .s_raddr(s_raddr), .s_rresp(a_s_rresp), .s_rdata(a_s_rdata),
    .m_wready(a_m_wready), .m_wvalid(m_wvalid), .m_waddr(a_m_waddr), .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb),
    .m_rready(a_m_rready), .m_rvalid(m_rvalid), .m_raddr(a_m_raddr), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .err_clr(err_clr), .err_o(a_err_o), .err_addr(a_err_addr), .err_wr(a_err_wr)
  );

  srv32_dbus_router #(.RD_LAT(3), .ERR_EN(1)) u_b (
    .clk(clk), .resetb(resetb),
    .s_wready(s_wready), .s_wvalid(b_s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rready(s_rready), .s_rvalid(b_s_rvalid), .s_raddr(s_raddr), .s_rresp(b_s_rresp), .s_rdata(b_s_rdata),
    .m_wready(b_m_wready), .m_wvalid(m_wvalid), .m_waddr(b_m_waddr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
    .m_rready(b_m_rready), .m_rvalid(m_rvalid), .m_raddr(b_m_raddr), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .err_clr(err_clr), .err_o(b_err_o), .err_addr(b_err_addr), .err_wr(b_err_wr)
  );

  srv32_dbus_router #(.RD_LAT(2)) u_c (
    .clk(clk), .resetb(resetb),
    .s_wready(s_wready), .s_wvalid(c_s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rready(s_rready), .s_rvalid(c_s_rvalid), .s_raddr(s_raddr), .s_rresp(c_s_rresp), .s_rdata(c_s_rdata),
    .m_wready(c_m_wready), .m_wvalid(m_wvalid), .m_waddr(c_m_waddr), .m_wdata(c_m_wdata), .m_wstrb(c_m_wstrb),
    .m_rready(c_m_rready), .m_rvalid(m_rvalid), .m_raddr(c_m_raddr), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .err_clr(err_clr), .err_o(c_err_o), .err_addr(c_err_addr), .err_wr(c_err_wr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    s_rready = 1'b1; s_raddr = 32'h9000_0000;
    #1;
    total++; if (a_s_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", a_s_rdata); else passed++;
    total++; if (a_s_rresp !== 1'b0) $display("FAIL rst_rresp got %b exp 0", a_s_rresp); else passed++;
    total++; if (a_err_o !== 1'b0) $display("FAIL rst_err_o got %b exp 0", a_err_o); else passed++;
    total++; if (b_err_addr !== 32'h0) $display("FAIL rst_err_addr got %h exp 0", b_err_addr); else passed++;
    total++; if (a_m_rready !== 2'b10) $display("FAIL rst_comb_rready got %b exp 10", a_m_rready); else passed++;
    s_rready = 1'b0; s_raddr = 32'h0;
    tick; tick;
    resetb = 1'b1;
    tick;
  endtask

  task automatic test_default_read;
    s_rready = 1'b1; s_raddr = 32'h9000_4000;
    #1;
    total++; if (a_m_rready !== 2'b10) $display("FAIL dflt_m_rready got %b exp 10", a_m_rready); else passed++;
    total++; if (a_s_rvalid !== 1'b1) $display("FAIL dflt_s_rvalid got %b exp 1", a_s_rvalid); else passed++;
    total++; if (a_m_raddr[63:32] !== 32'h9000_4000) $display("FAIL dflt_raddr_bcast got %h exp 90004000", a_m_raddr[63:32]); else passed++;
    tick;
    s_rready = 1'b0; s_raddr = 32'h0;
    total++; if (a_s_rdata !== 32'h1234) $display("FAIL dflt_rdata got %h exp 00001234", a_s_rdata); else passed++;
    total++; if (a_s_rresp !== 1'b1) $display("FAIL dflt_rresp got %b exp 1", a_s_rresp); else passed++;
    tick;
    total++; if (a_s_rdata !== 32'h0) $display("FAIL dflt_idle_rdata got %h exp 0", a_s_rdata); else passed++;
    total++; if (a_s_rresp !== 1'b0) $display("FAIL dflt_idle_rresp got %b exp 0", a_s_rresp); else passed++;
    repeat (4) tick;
  endtask

  task automatic test_back_to_back;
    s_rready = 1'b1; s_raddr = 32'h0000_0010;
    tick;
    s_raddr = 32'h9000_0000;
    tick;
    s_rready = 1'b0; s_raddr = 32'h0;
    total++; if (b_s_rresp !== 1'b0) $display("FAIL b2b_early got %b exp 0", b_s_rresp); else passed++;
    tick;
    total++; if (b_s_rdata !== 32'hAAAA_0000) $display("FAIL b2b_t0_rdata got %h exp aaaa0000", b_s_rdata); else passed++;
    total++; if (b_s_rresp !== 1'b1) $display("FAIL b2b_t0_rresp got %b exp 1", b_s_rresp); else passed++;
    tick;
    total++; if (b_s_rdata !== 32'h0000_1234) $display("FAIL b2b_t1_rdata got %h exp 00001234", b_s_rdata); else passed++;
    tick;
    total++; if (b_s_rresp !== 1'b0) $display("FAIL b2b_done_rresp got %b exp 0", b_s_rresp); else passed++;
    repeat (3) tick;
  endtask

  task automatic test_err_read;
    s_rready = 1'b1; s_raddr = 32'h5000_0008;
    #1;
    total++; if (b_s_rvalid !== 1'b1) $display("FAIL errrd_rvalid got %b exp 1", b_s_rvalid); else passed++;
    total++; if (b_m_rready !== 2'b00) $display("FAIL errrd_m_rready got %b exp 00", b_m_rready); else passed++;
    tick;
    s_rready = 1'b0; s_raddr = 32'h0;
    total++; if (b_err_o !== 1'b1) $display("FAIL errrd_err_o got %b exp 1", b_err_o); else passed++;
    total++; if (b_err_addr !== 32'h5000_0008) $display("FAIL errrd_err_addr got %h exp 50000008", b_err_addr); else passed++;
    total++; if (b_err_wr !== 1'b0) $display("FAIL errrd_err_wr got %b exp 0", b_err_wr); else passed++;
    tick; tick;
    total++; if (b_s_rdata !== 32'hDEAD_BEEF) $display("FAIL errrd_rdata got %h exp deadbeef", b_s_rdata); else passed++;
    total++; if (b_s_rresp !== 1'b0) $display("FAIL errrd_rresp got %b exp 0", b_s_rresp); else passed++;
    tick;
    total++; if (b_s_rdata !== 32'h0) $display("FAIL errrd_after got %h exp 0", b_s_rdata); else passed++;
  endtask

  task automatic test_err_capture;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    total++; if (b_err_o !== 1'b0) $display("FAIL cap_clear got %b exp 0", b_err_o); else passed++;
    s_wready = 1'b1; s_waddr = 32'h7000_0000; s_wstrb = 4'hF;
    #1;
    total++; if (b_s_wvalid !== 1'b1) $display("FAIL cap_wvalid got %b exp 1", b_s_wvalid); else passed++;
    total++; if (b_m_wready !== 2'b00) $display("FAIL cap_wr_dropped got %b exp 00", b_m_wready); else passed++;
    tick;
    s_wready = 1'b0;
    total++; if (b_err_addr !== 32'h7000_0000) $display("FAIL cap_wr_addr got %h exp 70000000", b_err_addr); else passed++;
    total++; if (b_err_wr !== 1'b1) $display("FAIL cap_wr_flag got %b exp 1", b_err_wr); else passed++;
    s_rready = 1'b1; s_raddr = 32'h6000_0000;
    tick;
    s_rready = 1'b0;
    total++; if (b_err_addr !== 32'h7000_0000) $display("FAIL cap_sticky_addr got %h exp 70000000", b_err_addr); else passed++;
    total++; if (b_err_wr !== 1'b1) $display("FAIL cap_sticky_wr got %b exp 1", b_err_wr); else passed++;
    err_clr = 1'b1; s_wready = 1'b1; s_waddr = 32'hA000_0000;
    tick;
    err_clr = 1'b0; s_wready = 1'b0;
    total++; if (b_err_o !== 1'b1) $display("FAIL cap_clr_new_err_o got %b exp 1", b_err_o); else passed++;
    total++; if (b_err_addr !== 32'hA000_0000) $display("FAIL cap_clr_new_addr got %h exp a0000000", b_err_addr); else passed++;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    s_rready = 1'b1; s_raddr = 32'h6000_0000;
    s_wready = 1'b1; s_waddr = 32'h7000_0000;
    tick;
    s_rready = 1'b0; s_wready = 1'b0;
    total++; if (b_err_addr !== 32'h6000_0000) $display("FAIL cap_both_addr got %h exp 60000000", b_err_addr); else passed++;
    total++; if (b_err_wr !== 1'b0) $display("FAIL cap_both_wr got %b exp 0", b_err_wr); else passed++;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_unmapped_write_default;
    s_wready = 1'b1; s_waddr = 32'h5000_0000; s_wdata = 32'h0000_CAFE; s_wstrb = 4'h3;
    #1;
    total++; if (a_m_wready !== 2'b01) $display("FAIL dfltwr_m_wready got %b exp 01", a_m_wready); else passed++;
    total++; if (a_s_wvalid !== 1'b1) $display("FAIL dfltwr_s_wvalid got %b exp 1", a_s_wvalid); else passed++;
    total++; if (a_m_wdata[63:32] !== 32'h0000_CAFE) $display("FAIL dfltwr_wdata_bcast got %h exp 0000cafe", a_m_wdata[63:32]); else passed++;
    total++; if (a_m_wstrb !== 8'h33) $display("FAIL dfltwr_wstrb_bcast got %h exp 33", a_m_wstrb); else passed++;
    tick;
    s_wready = 1'b0;
    total++; if (a_err_o !== 1'b0) $display("FAIL dfltwr_err_o got %b exp 0", a_err_o); else passed++;
  endtask

  task automatic test_reset_inflight;
    s_rready = 1'b1; s_raddr = 32'h9000_0000;
    tick;
    s_rready = 1'b0; s_raddr = 32'h0;
    resetb = 1'b0;
    #1;
    total++; if (c_s_rresp !== 1'b0) $display("FAIL rstfl_during got %b exp 0", c_s_rresp); else passed++;
    total++; if (c_err_o !== 1'b0) $display("FAIL rstfl_err_o got %b exp 0", c_err_o); else passed++;
    #1;
    resetb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (c_s_rresp !== 1'b0 || c_s_rdata !== 32'h0) $display("FAIL rstfl_after%0d got %b/%h exp 0/0", k, c_s_rresp, c_s_rdata); else passed++;
    end
  endtask

  initial begin
    resetb = 1'b1;
    s_wready = 1'b0; s_rready = 1'b0; err_clr = 1'b0;
    s_waddr = 32'h0; s_wdata = 32'h0; s_raddr = 32'h0; s_wstrb = 4'h0;
    m_wvalid = 2'b11; m_rvalid = 2'b11; m_rresp = 2'b11;
    m_rdata = {32'h0000_1234, 32'hAAAA_0000};
    #2;
    test_reset;
    test_default_read;
    test_back_to_back;
    test_err_read;
    test_err_capture;
    test_unmapped_write_default;
    test_reset_inflight;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/srv32_dbus_router.md
SRV32_DBUS_ROUTER -- requirements
Module: srv32_dbus_router

Interface
REQ-001 Parameter NUM_TGT, 2: number of downstream targets, range 1..8.
REQ-002 Parameter TAG_W, 4: decoded upper-address bits, addr[31:32-TAG_W].
REQ-003 Parameter TAGS, {4'h9,4'h0}: packed NUM_TGT*TAG_W tags; target i owns TAGS[i*TAG_W +: TAG_W].
REQ-004 Parameter RD_LAT, 1: cycles from read accept to read data, range 1..4.
REQ-005 Parameter ERR_EN, 0: 0 = unmapped addresses go to target 0; 1 = unmapped addresses get an error response.
REQ-006 Parameter ERR_DATA, 32'hDEADBEEF: read data returned for an unmapped read.
REQ-007 Ports: clk  in  1  clock; resetb  in  1  asynchronous active-low reset.
REQ-008 Core write ports: s_wready in 1; s_wvalid out 1; s_waddr in 32; s_wdata in 32; s_wstrb in 4.
REQ-009 Core read ports: s_rready in 1; s_rvalid out 1; s_raddr in 32; s_rresp out 1; s_rdata out 32.
REQ-010 Target write ports: m_wready out NUM_TGT; m_wvalid in NUM_TGT; m_waddr, m_wdata out NUM_TGT*32; m_wstrb out NUM_TGT*4.
REQ-011 Target read ports: m_rready out NUM_TGT; m_rvalid in NUM_TGT; m_raddr out NUM_TGT*32; m_rresp in NUM_TGT; m_rdata in NUM_TGT*32.
REQ-012 Error ports: err_clr in 1 (clear); err_o out 1 (sticky flag); err_addr out 32 (first faulting address); err_wr out 1 (1 = faulting access was a write).

Function
REQ-013 Decode shall be combinational; on duplicate tags the lowest matching index wins.
REQ-014 Address, data and strobe shall be broadcast to all targets; only the selected target's m_wready or m_rready shall assert.
REQ-015 s_wvalid and s_rvalid shall equal the selected target's m_wvalid and m_rvalid, combinationally.
REQ-016 When ERR_EN=1, an unmapped request shall drive no target ready and shall be accepted in the same cycle (s_wvalid or s_rvalid = 1).
REQ-017 A read is accepted when s_rready and s_rvalid are both 1; the router then pushes {valid, target index, err} into an RD_LAT-deep shift pipeline.
REQ-018 Exactly RD_LAT cycles after accept, s_rdata and s_rresp shall come from the captured target (m_rdata[idx], m_rresp[idx]) for one cycle, or be ERR_DATA and 0 for an error.
REQ-019 With no valid slot at pipeline output, s_rdata shall be 0 and s_rresp 0.
REQ-020 Back-to-back reads to different targets shall be accepted on consecutive cycles, and each response shall be steered independently.
REQ-021 If err_o is 0, the first unmapped access shall set err_o and capture err_addr and err_wr; later errors shall not overwrite them while err_o is 1.
REQ-022 err_clr clears err_o; when err_clr and a new error occur in the same cycle, the new error is captured and err_o stays 1.
REQ-023 If a read and a write are both unmapped in the same cycle, the read shall be captured.
REQ-024 An unmapped write shall be dropped, with no target strobe.

Reset
REQ-025 On resetb low, all pipeline slots, err_o, err_wr and err_addr shall clear to 0 immediately.
REQ-026 In-flight reads shall be discarded on reset, and no response shall appear after release.
REQ-027 Combinational outputs shall follow inputs during reset; s_rdata and s_rresp shall be 0.

Structure
REQ-028 Package srv32_bus_pkg shall hold the default tag constants (CLINT_BASE, DMEM_BASE), ERR_DATA, and the read-slot struct {valid, idx, err}.
REQ-029 Sub-module srv32_addr_decode (address -> one-hot hit, index, miss) shall be instantiated once for the read path and once for the write path.

Verification
REQ-030 Defaults: read 0x9000_4000 accepted by target 1 (m_rdata 0x1234) -> s_rdata=0x1234, s_rresp=1 one cycle later; target 0 m_rready stays 0.
REQ-031 RD_LAT=3: reads 0x0000_0010 (t0) then 0x9000_0000 (t1) on consecutive cycles -> data from t0 at cycle 3, then t1 at cycle 4.
REQ-032 ERR_EN=1: read 0x5000_0008 -> s_rvalid=1 same cycle, s_rdata=0xDEADBEEF, s_rresp=0, err_o=1, err_addr=0x5000_0008, err_wr=0.
REQ-033 ERR_EN=1: write 0x7000_0000 then read 0x6000_0000 -> err_addr stays 0x7000_0000, err_wr=1; err_clr together with a third error -> err_o stays 1, new address captured.
REQ-034 ERR_EN=0: write 0x5000_0000 -> m_wready[0]=1, err_o stays 0.
REQ-035 Assert resetb during an RD_LAT=2 read -> no s_rresp pulse after release; err_o=0.
